// File: rtl/serialize_pkg.sv
// Shared types for the serializer datapath and the TX framer: FSM state and
// beat-counter width helper.
package serialize_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } ser_state_e;

    // A one-beat word still needs a 1-bit counter so the port stays legal.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_valid_if.sv
// Minimal data-plus-valid handshake bundle used across the TX datapath.
interface data_valid_if #(
    parameter int unsigned DATA_W = 8
);

    logic [DATA_W-1:0] data;
    logic              valid;

    modport master (output data, output valid);
    modport slave  (input data, input valid);

endinterface

// File: rtl/parallel_load_shift_reg.sv
// Parallel-load shift register presenting one narrow slice at its head;
// the mirror of the enabled capture shift register.
module parallel_load_shift_reg #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PIPE_DEPTH = 4,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [PIPE_DEPTH*DATA_W-1:0] load_data,
    input  logic                         shift_en,
    output logic [DATA_W-1:0]            head_o
);

    localparam int unsigned TOTAL_W = PIPE_DEPTH * DATA_W;

    logic [TOTAL_W-1:0] sr_q;
    logic [TOTAL_W-1:0] shifted;

    if (PIPE_DEPTH == 1) begin : g_single
        assign shifted = sr_q;
        assign head_o  = sr_q;
    end else if (MSB_FIRST) begin : g_msb
        assign shifted = {sr_q[TOTAL_W-DATA_W-1:0], {DATA_W{1'b0}}};
        assign head_o  = sr_q[TOTAL_W-1 -: DATA_W];
    end else begin : g_lsb
        assign shifted = {{DATA_W{1'b0}}, sr_q[TOTAL_W-1:DATA_W]};
        assign head_o  = sr_q[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= load_data;
        end else if (shift_en) begin
            sr_q <= shifted;
        end
    end

endmodule

// File: rtl/serialize_value.sv
// Wide-to-narrow serializer: loads one wide word and streams it out one
// narrow beat per enabled cycle, with back-to-back reload on the last beat.
module serialize_value
    import serialize_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    data_valid_if.slave  load_data_if_i,
    output logic         ready_o,
    data_valid_if.master serial_data_if_o,
    output logic         overflow_o
);

    localparam int unsigned DATA_IN_W  = $bits(load_data_if_i.data);
    localparam int unsigned DATA_OUT_W = $bits(serial_data_if_o.data);
    localparam int unsigned PIPE_DEPTH = DATA_IN_W / DATA_OUT_W;
    localparam int unsigned CNT_W      = cnt_width(PIPE_DEPTH);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PIPE_DEPTH - 1);

    if (PIPE_DEPTH * DATA_OUT_W != DATA_IN_W || PIPE_DEPTH == 0) begin : g_width_check
        $error("serialize_value: input width must be a nonzero multiple of output width");
    end

    ser_state_e            state_q;
    logic [CNT_W-1:0]      beat_cnt_q;
    logic                  overflow_q;
    logic                  last_beat;
    logic                  load;
    logic                  shift_en;
    logic [DATA_OUT_W-1:0] head;

    assign last_beat = (beat_cnt_q == LAST_BEAT);
    // Ready in idle, or on the final enabled beat so the next word follows with no bubble.
    assign ready_o   = !rst && (state_q == StIdle || (last_beat && enable));
    assign load      = load_data_if_i.valid && ready_o;
    assign shift_en  = (state_q == StShift) && enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= load_data_if_i.valid && !ready_o;
            if (load) begin
                state_q    <= StShift;
                beat_cnt_q <= '0;
            end else if (shift_en) begin
                if (last_beat) begin
                    state_q    <= StIdle;
                    beat_cnt_q <= '0;
                end else begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                end
            end
        end
    end

    parallel_load_shift_reg #(
        .DATA_W    (DATA_OUT_W),
        .PIPE_DEPTH(PIPE_DEPTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(load_data_if_i.data),
        .shift_en (shift_en),
        .head_o   (head)
    );

    assign serial_data_if_o.valid = (state_q == StShift);
    assign serial_data_if_o.data  = head;
    assign overflow_o             = overflow_q;

endmodule

// File: tb/tb_serialize_value.sv
// Scoreboard bench for serialize_value: a 32-to-8 MSB-first and a 48-to-8
// LSB-first instance driven with directed words.
module tb_serialize_value;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    logic ready_a, ready_b, ovf_a, ovf_b;

    data_valid_if #(.DATA_W(32)) in_a ();
    data_valid_if #(.DATA_W(8))  out_a ();
    data_valid_if #(.DATA_W(48)) in_b ();
    data_valid_if #(.DATA_W(8))  out_b ();

    serialize_value #(.MSB_FIRST(1'b1)) u_dut_a (
        .clk             (clk),
        .rst             (rst),
        .enable          (en_a),
        .load_data_if_i  (in_a),
        .ready_o         (ready_a),
        .serial_data_if_o(out_a),
        .overflow_o      (ovf_a)
    );

    serialize_value #(.MSB_FIRST(1'b0)) u_dut_b (
        .clk             (clk),
        .rst             (rst),
        .enable          (en_b),
        .load_data_if_i  (in_b),
        .ready_o         (ready_b),
        .serial_data_if_o(out_b),
        .overflow_o      (ovf_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a beat is consumed whenever valid and enable are both high.
    always @(negedge clk) begin : mon_a
        logic [7:0] e;
        if (out_a.valid && en_a) begin
            if (exp_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_extra_beat: got %0h expected none", out_a.data);
            end else begin
                e = exp_a.pop_front();
                check("a_beat", 64'(out_a.data), 64'(e));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [7:0] e;
        if (out_b.valid && en_b) begin
            if (exp_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_extra_beat: got %0h expected none", out_b.data);
            end else begin
                e = exp_b.pop_front();
                check("b_beat", 64'(out_b.data), 64'(e));
            end
        end
    end

    logic [7:0] t2_bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        in_a.valid = 1'b0;
        in_a.data  = '0;
        in_b.valid = 1'b0;
        in_b.data  = '0;

        // Reset values
        repeat (2) cyc();
        @(negedge clk);
        check("rst_ready_a", 64'(ready_a), 64'(0));
        check("rst_ready_b", 64'(ready_b), 64'(0));
        check("rst_valid_a", 64'(out_a.valid), 64'(0));
        check("rst_data_a", 64'(out_a.data), 64'(0));
        check("rst_valid_b", 64'(out_b.valid), 64'(0));
        check("rst_data_b", 64'(out_b.data), 64'(0));
        check("rst_ovf_a", 64'(ovf_a), 64'(0));
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready_a", 64'(ready_a), 64'(1));
        check("post_rst_ready_b", 64'(ready_b), 64'(1));

        // Test 1: 0xDEADBEEF, enable held high
        cyc();
        in_a.valid = 1'b1;
        in_a.data  = 32'hDEADBEEF;
        en_a       = 1'b1;
        exp_a.push_back(8'hDE); exp_a.push_back(8'hAD);
        exp_a.push_back(8'hBE); exp_a.push_back(8'hEF);
        @(negedge clk);
        check("t1_ready_idle", 64'(ready_a), 64'(1));
        cyc();
        in_a.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_valid", 64'(out_a.valid), 64'(1));
            check("t1_ready", 64'(ready_a), 64'(i == 3));
            cyc();
        end
        @(negedge clk);
        check("t1_idle", 64'(out_a.valid), 64'(0));

        // Test 2: enable toggling, each byte held for two cycles
        cyc();
        in_a.valid = 1'b1;
        in_a.data  = 32'hA1B2C3D4;
        en_a       = 1'b0;
        for (int i = 0; i < 4; i++) exp_a.push_back(t2_bytes[i]);
        cyc();
        in_a.valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            en_a = (i % 2 == 1);
            @(negedge clk);
            check("t2_hold_data", 64'(out_a.data), 64'(t2_bytes[i/2]));
            check("t2_ready", 64'(ready_a), 64'(i == 7));
            cyc();
        end
        @(negedge clk);
        check("t2_idle", 64'(out_a.valid), 64'(0));

        // Test 3: back-to-back words with no bubble
        cyc();
        in_a.valid = 1'b1;
        in_a.data  = 32'h01020304;
        en_a       = 1'b1;
        exp_a.push_back(8'h01); exp_a.push_back(8'h02);
        exp_a.push_back(8'h03); exp_a.push_back(8'h04);
        exp_a.push_back(8'h0A); exp_a.push_back(8'h0B);
        exp_a.push_back(8'h0C); exp_a.push_back(8'h0D);
        cyc();
        for (int i = 0; i < 8; i++) begin
            in_a.valid = (i == 3);
            in_a.data  = 32'h0A0B0C0D;
            @(negedge clk);
            check("t3_contiguous", 64'(out_a.valid), 64'(1));
            if (i == 3) check("t3_ready_last", 64'(ready_a), 64'(1));
            cyc();
        end
        in_a.valid = 1'b0;
        @(negedge clk);
        check("t3_idle", 64'(out_a.valid), 64'(0));

        // Test 4: LSB-first 48-to-8
        cyc();
        in_b.valid = 1'b1;
        in_b.data  = 48'h112233445566;
        en_b       = 1'b1;
        exp_b.push_back(8'h66); exp_b.push_back(8'h55); exp_b.push_back(8'h44);
        exp_b.push_back(8'h33); exp_b.push_back(8'h22); exp_b.push_back(8'h11);
        cyc();
        in_b.valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_valid", 64'(out_b.valid), 64'(1));
            cyc();
        end
        @(negedge clk);
        check("t4_idle", 64'(out_b.valid), 64'(0));

        // Test 5: overflow while a word is in flight
        cyc();
        in_a.valid = 1'b1;
        in_a.data  = 32'hCAFEF00D;
        en_a       = 1'b1;
        exp_a.push_back(8'hCA); exp_a.push_back(8'hFE);
        exp_a.push_back(8'hF0); exp_a.push_back(8'h0D);
        cyc();
        in_a.valid = 1'b0;
        @(negedge clk);
        check("t5_ovf_beat0", 64'(ovf_a), 64'(0));
        cyc();
        in_a.valid = 1'b1;
        in_a.data  = 32'h12345678;
        @(negedge clk);
        check("t5_ready_busy", 64'(ready_a), 64'(0));
        check("t5_ovf_same", 64'(ovf_a), 64'(0));
        cyc();
        in_a.valid = 1'b0;
        @(negedge clk);
        check("t5_ovf_pulse", 64'(ovf_a), 64'(1));
        cyc();
        @(negedge clk);
        check("t5_ovf_clear", 64'(ovf_a), 64'(0));
        cyc();
        @(negedge clk);
        check("t5_idle", 64'(out_a.valid), 64'(0));

        // Test 6: reset during beat 2, then a fresh word
        cyc();
        in_a.valid = 1'b1;
        in_a.data  = 32'h55AA33CC;
        exp_a.push_back(8'h55); exp_a.push_back(8'hAA); exp_a.push_back(8'h33);
        cyc();
        in_a.valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("t6_valid_in_rst", 64'(out_a.valid), 64'(1));
        check("t6_ready_in_rst", 64'(ready_a), 64'(0));
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid_after", 64'(out_a.valid), 64'(0));
        check("t6_ready_after", 64'(ready_a), 64'(1));
        in_a.valid = 1'b1;
        in_a.data  = 32'h0F1E2D3C;
        exp_a.push_back(8'h0F); exp_a.push_back(8'h1E);
        exp_a.push_back(8'h2D); exp_a.push_back(8'h3C);
        cyc();
        in_a.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_fresh_valid", 64'(out_a.valid), 64'(1));
            cyc();
        end
        @(negedge clk);
        check("t6_idle", 64'(out_a.valid), 64'(0));

        cyc();
        check("a_queue_empty", 64'(exp_a.size()), 64'(0));
        check("b_queue_empty", 64'(exp_b.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
